// File: rtl/seven_seg_pkg.sv
// Shared constants and BCD-to-segment decode for the multiplexed 7-segment driver.
// Segment vectors are {a,b,c,d,e,f,g} with a in bit 6, active-high before polarity.
package seven_seg_pkg;

    localparam logic [6:0] SEG_OFF  = 7'b0000000;
    localparam logic [6:0] SEG_DASH = 7'b0000001;

    // Glyph table; non-decimal codes render as a dash so bad data is visible
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = 7'b1111110;
            4'd1:    seg = 7'b0110000;
            4'd2:    seg = 7'b1101101;
            4'd3:    seg = 7'b1111001;
            4'd4:    seg = 7'b0110011;
            4'd5:    seg = 7'b1011011;
            4'd6:    seg = 7'b1011111;
            4'd7:    seg = 7'b1110000;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1110011;
            default: seg = SEG_DASH;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Slot/digit scan timing: slot counter, digit index, frame boundary strobe,
// registered frame_done and the blink phase that toggles every BLINK_FRAMES frames.
module scan_timer
    import seven_seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned REFRESH_COUNT = 10000,
    parameter int unsigned BLINK_FRAMES  = 64,
    parameter int unsigned CNT_W         = $clog2(REFRESH_COUNT),
    parameter int unsigned IDX_W         = $clog2(NUM_DIGITS)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    output logic [CNT_W-1:0] o_cnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_boundary_c,
    output logic             o_frame_done,
    output logic             o_blink_on
);

    localparam int unsigned FR_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic [FR_W-1:0]  r_fcnt;
    logic             r_frame_done;
    logic             r_blink_on;
    logic             w_cnt_tc;
    logic             w_boundary;

    assign w_cnt_tc   = (r_cnt == CNT_W'(REFRESH_COUNT - 1));
    assign w_boundary = w_cnt_tc && (r_idx == IDX_W'(NUM_DIGITS - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_fcnt       <= '0;
            r_frame_done <= 1'b0;
            r_blink_on   <= 1'b1;
        end else begin
            r_frame_done <= w_boundary;
            if (w_cnt_tc) begin
                r_cnt <= '0;
                r_idx <= w_boundary ? '0 : r_idx + IDX_W'(1);
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            // Blink phase advances only on frame boundaries
            if (w_boundary) begin
                if (r_fcnt == FR_W'(BLINK_FRAMES - 1)) begin
                    r_fcnt     <= '0;
                    r_blink_on <= ~r_blink_on;
                end else begin
                    r_fcnt <= r_fcnt + FR_W'(1);
                end
            end
        end
    end

    assign o_cnt        = r_cnt;
    assign o_idx        = r_idx;
    assign o_boundary_c = w_boundary;
    assign o_frame_done = r_frame_done;
    assign o_blink_on   = r_blink_on;

endmodule

// File: rtl/display_scan_controller.sv
// Multiplexed 7-segment driver: frame-synchronous BCD update, anti-ghost blanking gap,
// leading-zero suppression, per-digit blink and configurable pin polarity.
module display_scan_controller
    import seven_seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned REFRESH_COUNT  = 10000,
    parameter int unsigned BLANK_CYCLES   = 16,
    parameter int unsigned BLINK_FRAMES   = 64,
    parameter int unsigned SEG_ACTIVE_LOW = 0,
    parameter int unsigned SEL_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] BCD_code,
    input  logic                    bcd_valid,
    input  logic                    lzb_en,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [6:0]              segments,
    output logic [NUM_DIGITS-1:0]   display_select,
    output logic                    frame_done
);

    localparam int unsigned CNT_W = $clog2(REFRESH_COUNT);
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
    localparam int unsigned BCD_W = 4 * NUM_DIGITS;

    localparam logic [6:0] SEG_IDLE = (SEG_ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;
    localparam logic [NUM_DIGITS-1:0] SEL_IDLE = (SEL_ACTIVE_LOW != 0) ? '1 : '0;

    logic [CNT_W-1:0]      w_cnt;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_boundary;
    logic                  w_blink_on;

    logic [BCD_W-1:0]      r_pending;
    logic [BCD_W-1:0]      r_active;
    logic                  r_pending_vld;

    logic [NUM_DIGITS-1:0] w_lzb_blank;
    logic                  w_zero_above;
    logic [3:0]            w_digit;
    logic                  w_blank;
    logic [6:0]            w_seg;
    logic [NUM_DIGITS-1:0] w_sel;

    scan_timer #(
        .NUM_DIGITS    (NUM_DIGITS),
        .REFRESH_COUNT (REFRESH_COUNT),
        .BLINK_FRAMES  (BLINK_FRAMES),
        .CNT_W         (CNT_W),
        .IDX_W         (IDX_W)
    ) u_scan_timer (
        .i_clk        (clk),
        .i_rst        (reset),
        .o_cnt        (w_cnt),
        .o_idx        (w_idx),
        .o_boundary_c (w_boundary),
        .o_frame_done (frame_done),
        .o_blink_on   (w_blink_on)
    );

    // Shadow/active pair: the displayed value only ever changes at a frame boundary
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending     <= '0;
            r_active      <= '0;
            r_pending_vld <= 1'b0;
        end else if (w_boundary) begin
            r_pending_vld <= 1'b0;
            if (bcd_valid) begin
                r_active <= BCD_code;
            end else if (r_pending_vld) begin
                r_active <= r_pending;
            end
        end else if (bcd_valid) begin
            r_pending     <= BCD_code;
            r_pending_vld <= 1'b1;
        end
    end

    // Digit i is a leading zero when it and every more significant digit are zero
    always_comb begin
        w_lzb_blank  = '0;
        w_zero_above = 1'b1;
        for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
            w_zero_above   = w_zero_above && (r_active[4*i +: 4] == 4'd0);
            w_lzb_blank[i] = lzb_en && w_zero_above;
        end
    end

    always_comb begin
        w_digit = 4'd0;
        w_blank = 1'b0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (w_idx == IDX_W'(i)) begin
                w_digit = r_active[4*i +: 4];
                w_blank = w_lzb_blank[i] || (blink_mask[i] && !w_blink_on);
            end
        end
    end

    // Selects stay inactive during the gap at each slot start to avoid ghosting
    always_comb begin
        w_seg = SEG_OFF;
        w_sel = '0;
        if (w_cnt >= CNT_W'(BLANK_CYCLES)) begin
            w_sel = NUM_DIGITS'(1) << w_idx;
            if (!w_blank) begin
                w_seg = bcd_to_seg(w_digit);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            segments       <= SEG_IDLE;
            display_select <= SEL_IDLE;
        end else begin
            segments       <= (SEG_ACTIVE_LOW != 0) ? ~w_seg : w_seg;
            display_select <= (SEL_ACTIVE_LOW != 0) ? ~w_sel : w_sel;
        end
    end

endmodule

// File: tb/tb_display_scan_controller.sv
// Randomized bench for display_scan_controller against a frame/time based reference model.
module tb_display_scan_controller;

    localparam int N     = 4;
    localparam int R     = 20;
    localparam int BLANK = 2;
    localparam int BF    = 2;
    localparam int F     = R * N;

    logic            clk;
    logic            reset;
    logic [4*N-1:0]  BCD_code;
    logic            bcd_valid;
    logic            lzb_en;
    logic [N-1:0]    blink_mask;
    logic [6:0]      segments;
    logic [N-1:0]    display_select;
    logic            frame_done;

    display_scan_controller #(
        .NUM_DIGITS     (N),
        .REFRESH_COUNT  (R),
        .BLANK_CYCLES   (BLANK),
        .BLINK_FRAMES   (BF),
        .SEG_ACTIVE_LOW (0),
        .SEL_ACTIVE_LOW (1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .BCD_code       (BCD_code),
        .bcd_valid      (bcd_valid),
        .lzb_en         (lzb_en),
        .blink_mask     (blink_mask),
        .segments       (segments),
        .display_select (display_select),
        .frame_done     (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] glyph [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                               7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                               7'b1111111, 7'b1110011, 7'b0000001, 7'b0000001,
                               7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001};

    int          n_checks;
    int          n_errors;
    int          t;
    bit          have_exp;
    logic [15:0] m_latest;
    logic [15:0] m_active;
    logic [6:0]  e_seg;
    logic [N-1:0] e_sel;
    logic        e_fd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0d", tag, got, exp, t);
        end
    endtask

    task automatic model_reset();
        t        = 0;
        m_latest = '0;
        m_active = '0;
        have_exp = 1'b0;
    endtask

    // Check the outputs of the previous cycle, drive this cycle, predict it, advance a cycle
    task automatic step(input logic valid, input logic [15:0] code);
        int  cnt;
        int  idx;
        int  frame;
        bit  phase_on;
        bit  blank;
        logic [15:0] upper;
        logic [3:0]  dig;
        if (have_exp) begin
            check("segments", 32'(segments), 32'(e_seg));
            check("select", 32'(display_select), 32'(e_sel));
            check("frame_done", 32'(frame_done), 32'(e_fd));
        end
        bcd_valid = valid;
        BCD_code  = code;
        cnt      = t % R;
        idx      = (t / R) % N;
        frame    = t / F;
        phase_on = ((frame / BF) % 2) == 0;
        e_fd     = ((t % F) == F - 1);
        if (cnt < BLANK) begin
            e_sel = '1;
            e_seg = 7'b0;
        end else begin
            e_sel = ~(N'(1) << idx);
            upper = m_active >> (4 * idx);
            dig   = upper[3:0];
            blank = (lzb_en && idx != 0 && upper == 16'd0) ||
                    (blink_mask[idx] && !phase_on);
            e_seg = blank ? 7'b0 : glyph[dig];
        end
        if (valid) m_latest = code;
        if ((t % F) == F - 1) m_active = m_latest;
        t++;
        have_exp = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 16'h0);
    endtask

    task automatic run_to_boundary();
        while ((t % F) != F - 1) step(1'b0, 16'h0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bcd_valid = 1'b0;
        @(negedge clk);
        check("rst_segments", 32'(segments), 32'h0);
        check("rst_select", 32'(display_select), 32'hF);
        check("rst_frame_done", 32'(frame_done), 32'h0);
        reset = 1'b0;
        model_reset();
    endtask

    function automatic logic [15:0] rand_code();
        case ($urandom_range(0, 3))
            0:       return 16'($urandom & 32'h0000_00FF);
            1:       return 16'($urandom & 32'h0000_0FFF);
            2:       return 16'($urandom_range(0, 9999) % 10 * 16'h0001 + 16'h0100);
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        reset      = 1'b1;
        bcd_valid  = 1'b0;
        BCD_code   = '0;
        lzb_en     = 1'b0;
        blink_mask = '0;
        model_reset();
        repeat (3) @(negedge clk);
        do_reset();

        // Plain load, mid-frame strobe, boundary strobe
        step(1'b1, 16'h1234);
        idle(2 * F);
        idle(30);
        step(1'b1, 16'h5678);
        idle(F);
        run_to_boundary();
        step(1'b1, 16'h9ABC);
        idle(F);

        // Leading-zero blanking and dash decode
        lzb_en = 1'b1;
        run_to_boundary();
        step(1'b1, 16'h0105);
        idle(F);
        run_to_boundary();
        step(1'b1, 16'h0000);
        idle(F);
        run_to_boundary();
        step(1'b1, 16'h00A9);
        idle(F);
        lzb_en = 1'b0;

        // Pending update lost to a mid-frame reset, then blink from a fresh frame count
        idle(10);
        step(1'b1, 16'h4321);
        idle(5);
        do_reset();
        blink_mask = 4'b0001;
        step(1'b1, 16'h8888);
        idle(6 * F);
        blink_mask = '0;

        // Randomized traffic with live lzb_en/blink_mask changes
        for (int k = 0; k < 40 * F; k++) begin
            if ($urandom_range(0, 199) == 0) lzb_en = 1'($urandom);
            if ($urandom_range(0, 299) == 0) blink_mask = N'($urandom);
            if (k == 17 * F + 37) do_reset();
            step(1'($urandom_range(0, 39) == 0), rand_code());
        end
        step(1'b0, 16'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
